// File: rtl/word_bank_arbiter.sv
// word_bank_arbiter: round-robin arbiter sharing one word-bank ROM between NUM_REQ requesters.
// Ports:
//   Clock, Reset  rising-edge clock, synchronous active-low reset
//   Start         new game: clears pointer, served count, pending strobes; aborts any fetch
//   Req           per-requester read strobes, latched into pending bits
//   RomData       ROM read data, valid ROM_LAT cycles after the RomEn cycle
//   RomEn/RomAddr ROM read enable and sequential address
//   WordOut       last delivered word, held until the next delivery
//   Valid         one-hot single-cycle pulse to the owner of WordOut
//   GrantIdx      current or last granted requester
//   Busy          high whenever a fetch is in progress
//   Exhausted     sticky once BANK_SIZE words have been delivered
module word_bank_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 5,
  parameter int BANK_SIZE = 18,
  parameter int ROM_LAT   = 1,
  parameter int WORD_W    = 64
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [WORD_W-1:0]          RomData,
  output logic                       RomEn,
  output logic [ADDR_W-1:0]          RomAddr,
  output logic [WORD_W-1:0]          WordOut,
  output logic [NUM_REQ-1:0]         Valid,
  output logic [$clog2(NUM_REQ)-1:0] GrantIdx,
  output logic                       Busy,
  output logic                       Exhausted
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ROM_LAT + 1);
  localparam int SW = $clog2(BANK_SIZE + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] pending, gsel;
  logic [ADDR_W-1:0] ptr;
  logic [SW-1:0] served;
  logic [CW-1:0] cnt;
  logic [GW-1:0] last_grant, pick, c;
  logic wait_done;
  assign gsel = NUM_REQ'(1) << GrantIdx;
  assign wait_done = state == WAIT && cnt == CW'(ROM_LAT - 1);
  assign RomAddr = ptr;
  // Scan offsets from farthest to nearest so the nearest pending requester after last_grant wins.
  always_comb begin
    pick = last_grant;
    c = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = GW'((int'(last_grant) + k) % NUM_REQ);
      if (pending[c]) pick = c;
    end
  end
  always_comb begin
    state_n = Start ? IDLE :
              state == IDLE  ? (|pending ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (wait_done ? DELIVER : WAIT) : IDLE;
    RomEn = state == ISSUE;
    Valid = state == DELIVER ? gsel : '0;
    Busy  = state != IDLE;
  end
  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pending    <= '0;
      ptr        <= '0;
      served     <= '0;
      cnt        <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      GrantIdx   <= '0;
      WordOut    <= '0;
      Exhausted  <= 1'b0;
    end else if (Start) begin
      pending   <= '0;
      ptr       <= '0;
      served    <= '0;
      Exhausted <= 1'b0;
    end else begin
      // A strobe on the clearing edge re-queues the requester.
      pending <= (pending & ~(wait_done ? gsel : '0)) | Req;
      cnt     <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == IDLE && |pending) begin
        GrantIdx   <= pick;
        last_grant <= pick;
      end
      if (wait_done) WordOut <= RomData;
      if (state == DELIVER) begin
        ptr       <= ptr == ADDR_W'(BANK_SIZE - 1) ? '0 : ptr + 1'b1;
        served    <= served == SW'(BANK_SIZE) ? served : served + 1'b1;
        Exhausted <= Exhausted | (served >= SW'(BANK_SIZE - 1));
      end
    end
  end
endmodule

// File: tb/tb_word_bank_arbiter.sv
// tb_word_bank_arbiter: scoreboard bench for the word-bank ROM arbiter.
module tb_word_bank_arbiter;
  logic Clock = 1'b0, Reset = 1'b0, Start = 1'b0;
  logic [2:0] Req = '0;
  logic [63:0] RomData = '0;
  logic RomEn, Busy, Exhausted;
  logic [4:0] RomAddr;
  logic [63:0] WordOut;
  logic [2:0] Valid;
  logic [1:0] GrantIdx;
  typedef struct {int g; int addr; bit exh;} exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0, exp_ptr = 0, exp_served = 0;

  word_bank_arbiter dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Req(Req), .RomData(RomData),
    .RomEn(RomEn), .RomAddr(RomAddr), .WordOut(WordOut), .Valid(Valid),
    .GrantIdx(GrantIdx), .Busy(Busy), .Exhausted(Exhausted)
  );

  always #5 Clock = ~Clock;

  function automatic logic [63:0] rom(input int a);
    return {32'hC0DE0000 | 32'(a), ~32'(a)};
  endfunction

  always @(posedge Clock) if (RomEn) RomData <= rom(int'(RomAddr));

  task automatic push(input int g);
    sb.push_back('{g, exp_ptr, exp_served >= 18});
    exp_ptr = (exp_ptr + 1) % 18;
    exp_served++;
  endtask

  always @(negedge Clock) begin : mon
    exp_t e;
    if (Reset) begin
      if (RomEn) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rom_en_unexpected: RomEn=1 addr=%0d, required no fetch", RomAddr);
        end else if (RomAddr !== 5'(sb[0].addr)) begin
          fails++;
          $display("FAIL rom_addr: got %0d, required %0d", RomAddr, sb[0].addr);
        end
      end
      if (Valid !== 3'b000) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL valid_unexpected: Valid=%b, required 000", Valid);
        end else begin
          e = sb.pop_front();
          if (Valid !== 3'(1 << e.g)) begin
            fails++;
            $display("FAIL valid_onehot: got %b, required %b", Valid, 3'(1 << e.g));
          end
          checks++;
          if (GrantIdx !== 2'(e.g)) begin
            fails++;
            $display("FAIL grant_idx: got %0d, required %0d", GrantIdx, e.g);
          end
          checks++;
          if (WordOut !== rom(e.addr)) begin
            fails++;
            $display("FAIL word_out: got %h, required %h (addr %0d)", WordOut, rom(e.addr), e.addr);
          end
          checks++;
          if (Exhausted !== e.exh) begin
            fails++;
            $display("FAIL exhausted_at_deliver: got %b, required %b (addr %0d)", Exhausted, e.exh, e.addr);
          end
        end
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b0;
    Start = 1'b0;
    Req = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    sb.delete();
    exp_ptr = 0;
    exp_served = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({RomEn, RomAddr, Valid, GrantIdx, Busy, Exhausted} !== 13'b0) begin
      fails++;
      $display("FAIL reset_outputs: RomEn=%b RomAddr=%0d Valid=%b GrantIdx=%0d Busy=%b Exhausted=%b, required all 0",
               RomEn, RomAddr, Valid, GrantIdx, Busy, Exhausted);
    end
    checks++;
    if (WordOut !== 64'h0) begin
      fails++;
      $display("FAIL reset_wordout: got %h, required 0", WordOut);
    end
    Reset = 1'b1;
    repeat (6) @(negedge Clock);
    checks++;
    if (Busy !== 1'b0 || RomEn !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: Busy=%b RomEn=%b, required 0 0", Busy, RomEn);
    end
  endtask

  task automatic test_single_fetch();
    Req = 3'b001;
    push(0);
    @(negedge Clock);
    Req = '0;
    checks++;
    if (RomEn !== 1'b0) begin
      fails++;
      $display("FAIL single_romen_c1: got %b, required 0", RomEn);
    end
    @(negedge Clock);
    checks++;
    if (RomEn !== 1'b1 || RomAddr !== 5'd0) begin
      fails++;
      $display("FAIL single_romen_c2: RomEn=%b RomAddr=%0d, required 1 0", RomEn, RomAddr);
    end
    @(negedge Clock);
    checks++;
    if (Valid !== 3'b000) begin
      fails++;
      $display("FAIL single_valid_c3: got %b, required 000", Valid);
    end
    @(negedge Clock);
    checks++;
    if (Valid !== 3'b001 || WordOut !== rom(0)) begin
      fails++;
      $display("FAIL single_valid_c4: Valid=%b WordOut=%h, required 001 %h", Valid, WordOut, rom(0));
    end
    @(negedge Clock);
    checks++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_after: got %b, required 0", Busy);
    end
  endtask

  task automatic test_contention();
    int t[$];
    Req = 3'b111;
    push(0);
    push(1);
    push(2);
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clock);
      if (i == 1) Req = '0;
      if (Valid !== 3'b000) t.push_back(i);
    end
    checks++;
    if (t.size() != 3) begin
      fails++;
      $display("FAIL contention_count: got %0d deliveries, required 3", t.size());
    end else begin
      checks++;
      if (t[0] != 4 || t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
        fails++;
        $display("FAIL contention_spacing: cycles %0d %0d %0d, required 4 8 12", t[0], t[1], t[2]);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL contention_drain: %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_fairness();
    Req = 3'b101;
    push(0);
    push(2);
    push(0);
    @(negedge Clock);
    Req = 3'b001;
    repeat (10) @(negedge Clock);
    Req = '0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge Clock);
    repeat (8) @(negedge Clock);
    checks++;
    if (sb.size() != 0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL fairness_drain: %0d outstanding Busy=%b, required 0 0", sb.size(), Busy);
      sb.delete();
    end
  endtask

  task automatic test_wrap_exhaust();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    exp_ptr = 0;
    exp_served = 0;
    checks++;
    if (Exhausted !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL start_clear: Exhausted=%b Busy=%b, required 0 0", Exhausted, Busy);
    end
    Req = 3'b010;
    for (int k = 0; k < 19; k++) push(1);
    repeat (72) @(negedge Clock);
    Req = '0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge Clock);
    repeat (8) @(negedge Clock);
    checks++;
    if (sb.size() != 0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL wrap_drain: %0d outstanding Busy=%b, required 0 0", sb.size(), Busy);
      sb.delete();
    end
    checks++;
    if (Exhausted !== 1'b1) begin
      fails++;
      $display("FAIL exhausted_sticky: got %b, required 1", Exhausted);
    end
  endtask

  task automatic test_abort();
    logic [63:0] old;
    old = WordOut;
    Req = 3'b100;
    push(2);
    @(negedge Clock);
    Req = '0;
    @(negedge Clock);
    @(negedge Clock);
    checks++;
    if (Busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy_wait: got %b, required 1", Busy);
    end
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    sb.delete();
    exp_ptr = 0;
    exp_served = 0;
    checks++;
    if (Valid !== 3'b000 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_state: Valid=%b Busy=%b, required 000 0", Valid, Busy);
    end
    checks++;
    if (WordOut !== old || Exhausted !== 1'b0) begin
      fails++;
      $display("FAIL abort_hold: WordOut=%h Exhausted=%b, required %h 0", WordOut, Exhausted, old);
    end
    repeat (4) @(negedge Clock);
    Req = 3'b001;
    push(0);
    @(negedge Clock);
    Req = '0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge Clock);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL abort_refetch: %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    do_reset();
    test_contention();
    test_fairness();
    test_wrap_exhaust();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: run still active at time %0t, required completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
